// File: rtl/squeeze_output_buffer.sv
// squeeze_output_buffer: captures cSHAKE squeeze words into a small FWFT FIFO
// and streams them out with byte-accurate last/keep marking and back-pressure.
// Optional build macro: SQUEEZE_OUTPUT_BYTESWAP_EN (byte-reverse each word on write).
module squeeze_output_buffer #(
  parameter int unsigned WOUT      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SKID      = 2,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic [WOUT-1:0]      din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [WOUT-1:0]      dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic [WOUT/8-1:0]    dout_keep,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int unsigned BYTES = WOUT / 8;
  localparam int unsigned TW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned LW1   = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] total_q, total_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic [TW-1:0]        tail_q, tail_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 din_ready_q, din_ready_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 zdone_q, zdone_d;

  logic [WOUT-1:0]      mem_data_q [DEPTH];
  logic                 mem_last_q [DEPTH];

  logic [WOUT-1:0]      din_w;
  logic [LW1-1:0]       len_ext;
  logic                 fifo_empty, fifo_full, head_last;
  logic                 we_try, wr_en, rd_en, wr_last;
  logic                 done_c;
  logic [BYTES-1:0]     keep_c;

  // Byte ordering applied to incoming words
  always_comb begin
    din_w = din;
`ifdef SQUEEZE_OUTPUT_BYTESWAP_EN
    for (int i = 0; i < int'(BYTES); i++) begin
      din_w[8*i +: 8] = din[8*(int'(BYTES)-1-i) +: 8];
    end
`endif
  end

  // Next-state, FIFO bookkeeping and handshake decode
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    acc_d       = acc_q;
    tail_d      = tail_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    zdone_d     = 1'b0;
    done_c      = zdone_q;
    len_ext     = LW1'({1'b0, out_len}) + LW1'(BYTES - 1);

    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CW'(DEPTH));
    head_last   = mem_last_q[rd_ptr_q];
    rd_en       = !fifo_empty && dout_ready;
    we_try      = (state_q == FILL) && din_valid && (acc_q < total_q);
    wr_en       = we_try && (!fifo_full || rd_en);
    wr_last     = ((acc_q + LEN_WIDTH'(1)) == total_q);

    // Accepted-word count advances even on a dropped word so the request ends
    if (we_try) begin
      acc_d = acc_q + LEN_WIDTH'(1);
      if (fifo_full && !rd_en) overflow_d = 1'b1;
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len != '0) begin
            state_d = FILL;
            total_d = LEN_WIDTH'(len_ext / LW1'(BYTES));
            tail_d  = TW'(out_len % LEN_WIDTH'(BYTES));
            acc_d   = '0;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (we_try && wr_last) state_d = DRAIN;
      end
      DRAIN: begin
        // An empty FIFO here means the last word was lost to overflow
        if ((rd_en && head_last) || fifo_empty) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    din_ready_d = (state_d == FILL) && ((CW'(DEPTH) - count_d) > CW'(SKID)) && (acc_d < total_d);
  end

  // Byte-lane valid mask for the FIFO head
  always_comb begin
    keep_c = '1;
    if (fifo_empty) begin
      keep_c = '0;
    end else if (head_last && (tail_q != '0)) begin
      for (int i = 0; i < int'(BYTES); i++) begin
`ifdef SQUEEZE_OUTPUT_BYTESWAP_EN
        keep_c[int'(BYTES)-1-i] = (TW'(i) < tail_q);
`else
        keep_c[i] = (TW'(i) < tail_q);
`endif
      end
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      acc_q       <= '0;
      tail_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      acc_q       <= acc_d;
      tail_q      <= tail_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      zdone_q     <= zdone_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= din_w;
      mem_last_q[wr_ptr_q] <= wr_last;
    end
  end

  assign din_ready  = din_ready_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign done       = done_c;
  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
  assign dout_last  = !fifo_empty && head_last;
  assign dout_keep  = keep_c;

endmodule

// File: tb/tb_squeeze_output_buffer.sv
// Self-checking bench for squeeze_output_buffer: scoreboard of expected words
// pushed on accepted input and popped on output handshake.
module tb_squeeze_output_buffer;

  localparam int WOUT  = 32;
  localparam int DEPTH = 8;
  localparam int SKID  = 2;
  localparam int LW    = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [LW-1:0]   out_len;
  logic [WOUT-1:0] din;
  logic            din_valid;
  logic            din_ready;
  logic [WOUT-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
  logic [3:0]      dout_keep;
  logic            busy;
  logic            done;
  logic            overflow;

  squeeze_output_buffer #(.WOUT(WOUT), .DEPTH(DEPTH), .SKID(SKID), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_len(out_len),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .dout_keep(dout_keep),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [3:0]  keep;
  } exp_t;

  exp_t sb[$];
  int   checks, errors;
  int   m_state, m_acc, m_total, m_tail;
  bit   m_ovf, m_zdone, mon_en, hold_din;
  int   done_cnt, words_out, last_cnt, dr_hi_cnt;
  logic [3:0]  last_keep_seen;
  logic [31:0] last_dout_seen;
  bit   p1, p2;

  int   cnt0;
  bit   rd, hd_last, exp_dr, exp_done, wr_try;
  exp_t e;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      m_state = 0; m_acc = 0; m_total = 0; m_tail = 0; m_ovf = 0; m_zdone = 0;
    end else if (mon_en) begin
      cnt0     = sb.size();
      rd       = (cnt0 > 0) && dout_ready;
      hd_last  = (cnt0 > 0) ? sb[0].last : 1'b0;
      exp_dr   = (m_state == 1) && ((DEPTH - cnt0) > SKID) && (m_acc < m_total);
      exp_done = m_zdone || ((m_state == 2) && ((rd && hd_last) || (cnt0 == 0)));

      checks++;
      if (dout_valid !== (cnt0 > 0)) begin errors++; $display("FAIL dout_valid got %b exp %b t=%0t", dout_valid, (cnt0 > 0), $time); end
      checks++;
      if (busy !== (m_state != 0)) begin errors++; $display("FAIL busy got %b exp %b t=%0t", busy, (m_state != 0), $time); end
      checks++;
      if (din_ready !== exp_dr) begin errors++; $display("FAIL din_ready got %b exp %b t=%0t", din_ready, exp_dr, $time); end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL overflow got %b exp %b t=%0t", overflow, m_ovf, $time); end
      checks++;
      if (done !== exp_done) begin errors++; $display("FAIL done got %b exp %b t=%0t", done, exp_done, $time); end

      if (done === 1'b1) done_cnt++;
      if (din_ready === 1'b1) dr_hi_cnt++;

      if (rd) begin
        e = sb.pop_front();
        checks++;
        if (dout !== e.d || dout_last !== e.last || dout_keep !== e.keep) begin
          errors++;
          $display("FAIL word got %h/%b/%b exp %h/%b/%b t=%0t", dout, dout_last, dout_keep, e.d, e.last, e.keep, $time);
        end
        words_out++;
        if (e.last) begin
          last_cnt++;
          last_keep_seen = dout_keep;
          last_dout_seen = dout;
        end
      end

      wr_try = (m_state == 1) && (din_valid === 1'b1) && (m_acc < m_total);
      if (wr_try) begin
        if (cnt0 < DEPTH || rd) begin
`ifdef SQUEEZE_OUTPUT_BYTESWAP_EN
          e.d = bswap(din);
`else
          e.d = din;
`endif
          e.last = (m_acc + 1 == m_total);
          if (e.last && m_tail != 0) begin
`ifdef SQUEEZE_OUTPUT_BYTESWAP_EN
            e.keep = 4'((4'hF << (4 - m_tail)) & 4'hF);
`else
            e.keep = 4'((1 << m_tail) - 1);
`endif
          end else begin
            e.keep = 4'hF;
          end
          sb.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
        m_acc++;
      end

      if (m_state == 0) begin
        m_zdone = 1'b0;
        if (start === 1'b1) begin
          if (out_len != 0) begin
            m_state = 1; m_total = (int'(out_len) + 3) / 4; m_tail = int'(out_len) % 4; m_acc = 0;
          end else begin
            m_zdone = 1'b1;
          end
        end
      end else if (m_state == 1) begin
        if (wr_try && m_acc == m_total) m_state = 2;
      end else if (exp_done) begin
        m_state = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int len);
    cyc();
    start = 1'b1; out_len = LW'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; dout_ready = 1'b0; start = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Drives random words (optionally lagging din_ready by two cycles) until done or budget
  task automatic run_req(input int budget, input bit lag, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0; p1 = 1'b0; p2 = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (!hold_din) din = $urandom;
      if (lag) begin din_valid = p2; p2 = p1; p1 = din_ready; end
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if (din_ready !== 1'b0)  begin errors++; $display("FAIL rst_din_ready got %b exp 0", din_ready); end
    checks++; if (dout !== 32'h0)      begin errors++; $display("FAIL rst_dout got %h exp 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", dout_valid); end
    checks++; if (dout_last !== 1'b0)  begin errors++; $display("FAIL rst_dout_last got %b exp 0", dout_last); end
    checks++; if (dout_keep !== 4'h0)  begin errors++; $display("FAIL rst_dout_keep got %h exp 0", dout_keep); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    #20;
    @(negedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_full_words();
    int w0 = words_out, l0 = last_cnt;
    bit ok;
    start_req(12);
    din_valid = 1'b1; dout_ready = 1'b1;
    run_req(40, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL len12_done got timeout exp pulse"); end
    checks++; if (words_out - w0 != 3) begin errors++; $display("FAIL len12_words got %0d exp 3", words_out - w0); end
    checks++; if (last_cnt - l0 != 1) begin errors++; $display("FAIL len12_last got %0d exp 1", last_cnt - l0); end
    checks++; if (last_keep_seen !== 4'hF) begin errors++; $display("FAIL len12_keep got %b exp 1111", last_keep_seen); end
    idle(3);
  endtask

  task automatic test_partial();
    int w0 = words_out;
    bit ok;
    logic [3:0]  k_exp;
    logic [31:0] d_exp;
`ifdef SQUEEZE_OUTPUT_BYTESWAP_EN
    k_exp = 4'b1100; d_exp = 32'h44332211;
`else
    k_exp = 4'b0011; d_exp = 32'h11223344;
`endif
    hold_din = 1'b1; din = 32'h11223344;
    start_req(10);
    din_valid = 1'b1; dout_ready = 1'b1;
    run_req(40, 1'b0, ok);
    hold_din = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL len10_done got timeout exp pulse"); end
    checks++; if (words_out - w0 != 3) begin errors++; $display("FAIL len10_words got %0d exp 3", words_out - w0); end
    checks++; if (last_keep_seen !== k_exp) begin errors++; $display("FAIL len10_keep got %b exp %b", last_keep_seen, k_exp); end
    checks++; if (last_dout_seen !== d_exp) begin errors++; $display("FAIL len10_dout got %h exp %h", last_dout_seen, d_exp); end
    idle(3);
  endtask

  task automatic test_back_pressure();
    int w0 = words_out, l0 = last_cnt, r0;
    bit ok;
    start_req(64);
    dout_ready = 1'b0;
    run_req(20, 1'b1, ok);
    checks++; if (ok) begin errors++; $display("FAIL bp_early_done got 1 exp 0"); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready got %b exp 0", din_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b exp 0", overflow); end
    r0 = dr_hi_cnt;
    dout_ready = 1'b1;
    run_req(200, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done got timeout exp pulse"); end
    checks++; if (words_out - w0 != 16) begin errors++; $display("FAIL bp_words got %0d exp 16", words_out - w0); end
    checks++; if (last_cnt - l0 != 1) begin errors++; $display("FAIL bp_last got %0d exp 1", last_cnt - l0); end
    checks++; if (dr_hi_cnt == r0) begin errors++; $display("FAIL bp_resume got %0d exp >0 din_ready cycles", dr_hi_cnt - r0); end
    idle(3);
  endtask

  task automatic test_full_rw();
    int w0 = words_out;
    bit ok;
    start_req(64);
    din_valid = 1'b1; dout_ready = 1'b0;
    for (int i = 0; i < 20 && sb.size() < DEPTH; i++) begin
      din = $urandom;
      cyc();
    end
    dout_ready = 1'b1;
    run_req(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fullrw_done got timeout exp pulse"); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got %b exp 0", overflow); end
    checks++; if (words_out - w0 != 16) begin errors++; $display("FAIL fullrw_words got %0d exp 16", words_out - w0); end
    idle(3);
  endtask

  task automatic test_overflow();
    int w0 = words_out, l0 = last_cnt;
    bit ok;
    start_req(64);
    din_valid = 1'b1; dout_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      din = $urandom;
      cyc();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", busy); end
    dout_ready = 1'b1;
    run_req(60, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_done got timeout exp pulse"); end
    checks++; if (words_out - w0 != 8) begin errors++; $display("FAIL ovf_words got %0d exp 8", words_out - w0); end
    checks++; if (last_cnt - l0 != 0) begin errors++; $display("FAIL ovf_last got %0d exp 0", last_cnt - l0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    idle(3);
  endtask

  task automatic test_zero_and_busy_start();
    int d0 = done_cnt, w0 = words_out;
    bit ok;
    start_req(0);
    cyc(); cyc();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt - d0); end
    checks++; if (words_out != w0 || dout_valid !== 1'b0) begin errors++; $display("FAIL zero_words got %0d exp 0", words_out - w0); end
    start_req(16);
    din_valid = 1'b1; dout_ready = 1'b1;
    cyc(); din = $urandom;
    start = 1'b1; out_len = LW'(40);
    cyc(); din = $urandom;
    start = 1'b0;
    run_req(40, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done got timeout exp pulse"); end
    idle(6);
    checks++; if (words_out - w0 != 4) begin errors++; $display("FAIL ign_words got %0d exp 4", words_out - w0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int d0, w0;
    bit ok;
    start_req(20);
    din_valid = 1'b1; dout_ready = 1'b0; din = $urandom;
    cyc(); din = $urandom;
    cyc();
    din_valid = 1'b0;
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL rmid_dout got %b/%h exp 0/0", dout_valid, dout); end
    checks++; if (busy !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got %b/%b exp 0/0", busy, din_ready); end
    checks++; if (done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b/%b exp 0/0", done, overflow); end
    checks++; if (dout_last !== 1'b0 || dout_keep !== 4'h0) begin errors++; $display("FAIL rmid_mark got %b/%h exp 0/0", dout_last, dout_keep); end
    #10 rst = 1'b1;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rmid_nodone got %0d exp 0", done_cnt - d0); end
    w0 = words_out;
    start_req(4);
    din_valid = 1'b1; dout_ready = 1'b1;
    run_req(40, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_done got timeout exp pulse"); end
    checks++; if (words_out - w0 != 1) begin errors++; $display("FAIL rmid_words got %0d exp 1", words_out - w0); end
    checks++; if (last_keep_seen !== 4'hF) begin errors++; $display("FAIL rmid_keep got %b exp 1111", last_keep_seen); end
    idle(3);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_len = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    mon_en = 1'b0; hold_din = 1'b0; checks = 0; errors = 0;
    done_cnt = 0; words_out = 0; last_cnt = 0; dr_hi_cnt = 0;
    last_keep_seen = '0; last_dout_seen = '0;
    test_reset();
    test_full_words();
    test_partial();
    test_back_pressure();
    test_full_rw();
    test_zero_and_busy_start();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/squeeze_output_buffer.md
Name: squeeze_output_buffer

Overview:
- Sits directly downstream of the cSHAKE datapath. Captures the WOUT-bit hash words the datapath emits during the squeeze phase.
- Buffers them in a small FIFO and presents them on a valid/ready output stream, with byte-accurate length and last/keep marking.
- Gives the squeeze controller back-pressure (din_ready), because the datapath output is registered and cannot be stalled in the same cycle.

Parameters:
- WOUT, 32, datapath output word width in bits (multiple of 8, max 64).
- DEPTH, 8, FIFO entries (power of 2, >= 4).
- SKID, 2, free entries kept in reserve when din_ready deasserts (covers datapath output latency).
- LEN_WIDTH, 16, width of the requested output length in bytes.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begin a squeeze of out_len bytes
- out_len  input  LEN_WIDTH  requested output bytes, sampled on start
- din  input  WOUT  hash word from datapath dout
- din_valid  input  1  din holds a valid word this cycle
- din_ready  output  1  controller may issue further squeeze reads
- dout  output  WOUT  output word, FIFO head
- dout_valid  output  1  dout valid
- dout_ready  input  1  consumer accepts dout
- dout_last  output  1  dout is the final word of the request
- dout_keep  output  WOUT/8  valid byte lanes of dout; bit 0 = bits 7:0
- busy  output  1  request in progress
- done  output  1  one-cycle pulse when the request completes
- overflow  output  1  sticky; a word arrived while the FIFO was full

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: din_ready=0, dout=0, dout_valid=0, dout_last=0, dout_keep=0, busy=0, done=0, overflow=0.
  - FIFO pointers and counters cleared; state=IDLE.
  - Reset asserted mid-request discards all buffered data. No done pulse is produced.
- Derived values:
  - words_total = ceil(out_len / (WOUT/8)), computed at start.
  - tail_bytes = out_len mod (WOUT/8); 0 means a full word.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE + start with out_len != 0 -> FILL; busy=1 from the next cycle.
  - IDLE + start with out_len == 0 -> stays IDLE; done pulses one cycle after start; no output words.
  - FILL: a word is written when din_valid=1 and fewer than words_total words have been accepted. Excess din_valid words are dropped silently.
  - FILL -> DRAIN in the cycle after the words_total-th word is written.
  - DRAIN -> IDLE when the last word handshakes (dout_valid & dout_ready & dout_last). done pulses in the same cycle as that handshake; busy=0 from the next cycle.
  - start while busy=1 is ignored.
- din_ready:
  - Registered; equals 1 in FILL when free entries > SKID and accepted words < words_total.
  - 0 in IDLE and DRAIN.
- FIFO:
  - First-word fall-through; dout_valid=1 whenever the FIFO is non-empty.
  - Simultaneous write and read when full is allowed only if the read frees the slot in the same cycle; the write then succeeds.
  - A write when full with no read: word dropped, overflow=1 until reset. Accepted-word count still advances so that the request terminates.
  - Simultaneous write and read when empty: the word appears on dout the next cycle (no bypass).
- dout_last / dout_keep:
  - dout_last=1 only on the words_total-th word.
  - dout_keep is all ones, except on the last word when tail_bytes != 0: the low tail_bytes bits are set.
  - dout is held stable while dout_valid=1 and dout_ready=0.
- Counters are LEN_WIDTH bits; out_len = 2^LEN_WIDTH-1 must not wrap.

Optional Feature:
- Macro: SQUEEZE_OUTPUT_BYTESWAP_EN.
- Defined: each word is byte-reversed on write (din byte i -> dout byte WOUT/8-1-i). dout_keep then marks the high tail_bytes lanes on a partial last word.
- Undefined: bytes pass in datapath order and keep marks the low lanes.

Test Plan:
- out_len=12, WOUT=32, dout_ready=1, din_valid every cycle:
  - 3 words emitted; dout_last on word 3; dout_keep=4'b1111 throughout.
  - done pulses with the 3rd handshake; busy falls the next cycle.
- out_len=10:
  - 3 words emitted; last word dout_keep=4'b0011.
  - With SQUEEZE_OUTPUT_BYTESWAP_EN: last word keep=4'b1100; din 32'h11223344 -> dout 32'h44332211.
- out_len=64, dout_ready=0, din_valid held high while din_ready=1:
  - din_ready drops at 6 entries with DEPTH=8, SKID=2.
  - Two in-flight words still accepted; FIFO full; overflow stays 0.
  - Releasing dout_ready drains the FIFO and resumes din_ready.
- FIFO full, din_valid=1 with dout_ready=0 -> overflow=1 and the word is lost. Same situation with dout_ready=1 -> no overflow.
- start with out_len=0 -> done one cycle later; dout_valid never asserts. start pulsed during a busy 16-byte request -> ignored, and exactly 4 words are emitted.
- rst driven low after 2 of 5 words have been accepted:
  - All outputs go to 0 immediately, with no done pulse.
  - A new start with out_len=4 then yields one word with keep=4'b1111.
